// File: rtl/img_rsz_pxl_buf.sv
// img_rsz_pxl_buf: first-word-fall-through buffer between the resize compute engine and the pixel output stream, with overflow, mask and raster-order checking
module img_rsz_pxl_buf #(
    parameter int PXL_PRIM_COLOR_NUM  = 3,
    parameter int PXL_PRIM_COLOR_W    = 8,
    parameter int RSZ_IMG_WIDTH_SIZE  = 8,
    parameter int RSZ_IMG_HEIGHT_SIZE = 8,
    parameter int BUF_DEPTH           = 4
) (
    input  logic                                           Clk,
    input  logic                                           Reset,
    input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] CeRszPxlData,
    input  logic [RSZ_IMG_WIDTH_SIZE-1:0]                  CeRszPxlXMsk,
    input  logic [RSZ_IMG_HEIGHT_SIZE-1:0]                 CeRszPxlYMsk,
    input  logic                                           CeCompVld,
    output logic                                           PxlBufRdy,
    output logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] RszPxlData,
    output logic [$clog2(RSZ_IMG_WIDTH_SIZE)-1:0]          RszPxlXIdx,
    output logic [$clog2(RSZ_IMG_HEIGHT_SIZE)-1:0]         RszPxlYIdx,
    output logic                                           RszPxlLast,
    output logic                                           RszPxlVld,
    input  logic                                           RszPxlRdy,
    output logic                                           RszImgComp,
    output logic [$clog2(BUF_DEPTH):0]                     BufCnt,
    output logic                                           BufOvf,
    output logic                                           MskErr,
    output logic                                           OrdErr
);
    localparam int DW = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;
    localparam int XW = $clog2(RSZ_IMG_WIDTH_SIZE);
    localparam int YW = $clog2(RSZ_IMG_HEIGHT_SIZE);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {STREAM, CMPL} state_t;

    state_t               state, stateNxt;
    logic [DW-1:0]        memData [BUF_DEPTH];
    logic [XW-1:0]        memX [BUF_DEPTH];
    logic [YW-1:0]        memY [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] memLast;
    logic [PW-1:0]        wrPtr, rdPtr;
    logic [XW-1:0]        wrX, expX;
    logic [YW-1:0]        wrY, expY;
    logic                 full, push, pop, xOneHot, yOneHot;

    assign full      = BufCnt == CW'(BUF_DEPTH);
    assign pop       = RszPxlVld & RszPxlRdy;
    assign push      = CeCompVld & (~full | pop);
    assign RszPxlVld = BufCnt != '0;
    assign PxlBufRdy = BufCnt <= CW'(BUF_DEPTH - 2);
    assign xOneHot   = (CeRszPxlXMsk != '0) && ((CeRszPxlXMsk & (CeRszPxlXMsk - RSZ_IMG_WIDTH_SIZE'(1))) == '0);
    assign yOneHot   = (CeRszPxlYMsk != '0) && ((CeRszPxlYMsk & (CeRszPxlYMsk - RSZ_IMG_HEIGHT_SIZE'(1))) == '0);

    assign RszPxlData = memData[rdPtr];
    assign RszPxlXIdx = memX[rdPtr];
    assign RszPxlYIdx = memY[rdPtr];
    assign RszPxlLast = memLast[rdPtr];

    // Decode each mask to its lowest set bit; an empty mask decodes to 0
    always_comb begin
        wrX = '0;
        wrY = '0;
        for (int i = RSZ_IMG_WIDTH_SIZE - 1; i >= 0; i--) if (CeRszPxlXMsk[i]) wrX = XW'(i);
        for (int i = RSZ_IMG_HEIGHT_SIZE - 1; i >= 0; i--) if (CeRszPxlYMsk[i]) wrY = YW'(i);
    end

    // Entry storage; contents need no reset since BufCnt qualifies them
    always_ff @(posedge Clk) begin
        if (push & ~Reset) begin
            memData[wrPtr] <= CeRszPxlData;
            memX[wrPtr]    <= wrX;
            memY[wrPtr]    <= wrY;
            memLast[wrPtr] <= CeRszPxlXMsk[RSZ_IMG_WIDTH_SIZE-1] & CeRszPxlYMsk[RSZ_IMG_HEIGHT_SIZE-1];
        end
    end

    // Pointers, occupancy, expected raster position and sticky error flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            BufCnt <= '0;
            expX   <= '0;
            expY   <= '0;
            BufOvf <= 1'b0;
            MskErr <= 1'b0;
            OrdErr <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop) rdPtr <= rdPtr + PW'(1);
            BufCnt <= BufCnt + CW'(push) - CW'(pop);
            if (pop) begin
                if (RszPxlLast) begin
                    expX <= '0;
                    expY <= '0;
                end else if (expX == XW'(RSZ_IMG_WIDTH_SIZE - 1)) begin
                    expX <= '0;
                    expY <= expY + YW'(1);
                end else begin
                    expX <= expX + XW'(1);
                end
            end
            BufOvf <= BufOvf | (CeCompVld & full & ~pop);
            MskErr <= MskErr | (push & ~(xOneHot & yOneHot));
            OrdErr <= OrdErr | (pop & ((RszPxlXIdx != expX) | (RszPxlYIdx != expY)));
        end
    end

    // Image-completion state register
    always_ff @(posedge Clk) begin
        if (Reset) state <= STREAM;
        else state <= stateNxt;
    end

    // Leave STREAM on the last-pixel handshake, return after one cycle
    always_comb begin
        stateNxt = (state == STREAM) ? ((pop & RszPxlLast) ? CMPL : STREAM) : STREAM;
    end

    // Completion pulse is the CMPL state itself
    always_comb begin
        RszImgComp = state == CMPL;
    end
endmodule

// File: tb/tb_img_rsz_pxl_buf.sv
// tb_img_rsz_pxl_buf: scoreboard bench for the resize pixel buffer at W=H=4, depth 4
module tb_img_rsz_pxl_buf;
    localparam int DW = 24;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [DW-1:0] CeRszPxlData = '0;
    logic [3:0]    CeRszPxlXMsk = '0;
    logic [3:0]    CeRszPxlYMsk = '0;
    logic          CeCompVld = 1'b0;
    logic          PxlBufRdy;
    logic [DW-1:0] RszPxlData;
    logic [1:0]    RszPxlXIdx;
    logic [1:0]    RszPxlYIdx;
    logic          RszPxlLast;
    logic          RszPxlVld;
    logic          RszPxlRdy = 1'b0;
    logic          RszImgComp;
    logic [2:0]    BufCnt;
    logic          BufOvf;
    logic          MskErr;
    logic          OrdErr;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    x;
        logic [1:0]    y;
        logic          l;
    } beat_t;

    beat_t sb[$];
    beat_t e;
    int    errors = 0;
    int    checks = 0;
    int    compPulses = 0;
    logic  expComp = 1'b0;

    img_rsz_pxl_buf #(
        .PXL_PRIM_COLOR_NUM(3),
        .PXL_PRIM_COLOR_W(8),
        .RSZ_IMG_WIDTH_SIZE(4),
        .RSZ_IMG_HEIGHT_SIZE(4),
        .BUF_DEPTH(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .CeRszPxlData(CeRszPxlData),
        .CeRszPxlXMsk(CeRszPxlXMsk),
        .CeRszPxlYMsk(CeRszPxlYMsk),
        .CeCompVld(CeCompVld),
        .PxlBufRdy(PxlBufRdy),
        .RszPxlData(RszPxlData),
        .RszPxlXIdx(RszPxlXIdx),
        .RszPxlYIdx(RszPxlYIdx),
        .RszPxlLast(RszPxlLast),
        .RszPxlVld(RszPxlVld),
        .RszPxlRdy(RszPxlRdy),
        .RszImgComp(RszImgComp),
        .BufCnt(BufCnt),
        .BufOvf(BufOvf),
        .MskErr(MskErr),
        .OrdErr(OrdErr)
    );

    always #5 Clk = ~Clk;

    // Output monitor: every handshake is compared against the scoreboard head, and the completion pulse against the previous handshake
    always @(negedge Clk) begin
        checks++;
        if (RszImgComp !== expComp) begin
            errors++;
            $display("FAIL img_comp got=%b exp=%b t=%0t", RszImgComp, expComp, $time);
        end
        if (RszImgComp === 1'b1) compPulses++;
        expComp = 1'b0;
        if (!Reset && RszPxlVld === 1'b1 && RszPxlRdy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got x=%0d y=%0d exp=none t=%0t", RszPxlXIdx, RszPxlYIdx, $time);
            end else begin
                e = sb.pop_front();
                expComp = e.l;
                if ({RszPxlData, RszPxlXIdx, RszPxlYIdx, RszPxlLast} !== e) begin
                    errors++;
                    $display("FAIL pop_data got d=%h x=%0d y=%0d l=%b exp d=%h x=%0d y=%0d l=%b t=%0t",
                             RszPxlData, RszPxlXIdx, RszPxlYIdx, RszPxlLast, e.d, e.x, e.y, e.l, $time);
                end
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic wrm(input logic [3:0] xm, input logic [3:0] ym, input logic [1:0] ex, input logic [1:0] ey, input bit keep);
        logic [DW-1:0] d;
        d = DW'($urandom);
        CeCompVld    = 1'b1;
        CeRszPxlXMsk = xm;
        CeRszPxlYMsk = ym;
        CeRszPxlData = d;
        if (keep) sb.push_back({d, ex, ey, xm[3] & ym[3]});
    endtask

    task automatic idle;
        CeCompVld    = 1'b0;
        CeRszPxlXMsk = '0;
        CeRszPxlYMsk = '0;
    endtask

    task automatic do_reset;
        idle();
        Reset = 1'b1;
        sb.delete();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset     = 1'b1;
        CeCompVld = 1'b1;
        RszPxlRdy = 1'b1;
        tick();
        tick();
        @(negedge Clk);
        checks++;
        if ({RszPxlVld, BufCnt, PxlBufRdy, RszImgComp, BufOvf, MskErr, OrdErr} !== {1'b0, 3'd0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state got vld=%b cnt=%0d rdy=%b comp=%b ovf=%b msk=%b ord=%b exp vld=0 cnt=0 rdy=1 comp=0 flags=0",
                     RszPxlVld, BufCnt, PxlBufRdy, RszImgComp, BufOvf, MskErr, OrdErr);
        end
        idle();
        RszPxlRdy = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_full_image;
        compPulses = 0;
        RszPxlRdy  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wrm(4'(1 << (i % 4)), 4'(1 << (i / 4)), 2'(i % 4), 2'(i / 4), 1'b1);
            @(negedge Clk);
            if (i > 0) begin
                checks++;
                if (RszPxlVld !== 1'b1 || BufCnt !== 3'd1 || RszPxlXIdx !== 2'((i - 1) % 4)) begin
                    errors++;
                    $display("FAIL image_latency beat=%0d got vld=%b cnt=%0d x=%0d exp vld=1 cnt=1 x=%0d", i - 1, RszPxlVld, BufCnt, RszPxlXIdx, (i - 1) % 4);
                end
            end
            tick();
        end
        idle();
        @(negedge Clk);
        checks++;
        if (RszPxlVld !== 1'b1 || RszPxlLast !== 1'b1 || {RszPxlXIdx, RszPxlYIdx} !== 4'b1111) begin
            errors++;
            $display("FAIL image_last got vld=%b last=%b x=%0d y=%0d exp vld=1 last=1 x=3 y=3", RszPxlVld, RszPxlLast, RszPxlXIdx, RszPxlYIdx);
        end
        repeat (3) tick();
        @(negedge Clk);
        checks++;
        if (compPulses !== 1 || sb.size() !== 0 || RszPxlVld !== 1'b0 || {BufOvf, MskErr, OrdErr} !== 3'b000) begin
            errors++;
            $display("FAIL image_end got pulses=%0d left=%0d vld=%b flags=%b%b%b exp pulses=1 left=0 vld=0 flags=000",
                     compPulses, sb.size(), RszPxlVld, BufOvf, MskErr, OrdErr);
        end
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        RszPxlRdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wrm(4'(1 << k), 4'b0001, 2'(k), 2'd0, 1'b1);
            @(negedge Clk);
            checks++;
            if (PxlBufRdy !== 1'b1 || BufCnt !== 3'(k)) begin
                errors++;
                $display("FAIL bp_fill got rdy=%b cnt=%0d exp rdy=1 cnt=%0d", PxlBufRdy, BufCnt, k);
            end
            tick();
        end
        wrm(4'b1000, 4'b0001, 2'd3, 2'd0, 1'b1);
        @(negedge Clk);
        checks++;
        if (PxlBufRdy !== 1'b0 || BufCnt !== 3'd3) begin
            errors++;
            $display("FAIL bp_rdy_fall got rdy=%b cnt=%0d exp rdy=0 cnt=3", PxlBufRdy, BufCnt);
        end
        tick();
        idle();
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (BufCnt !== 3'd4 || BufOvf !== 1'b0 || RszPxlData !== sb[0].d || RszPxlXIdx !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold got cnt=%0d ovf=%b d=%h x=%0d exp cnt=4 ovf=0 d=%h x=0", BufCnt, BufOvf, RszPxlData, RszPxlXIdx, sb[0].d);
            end
            tick();
        end
    endtask

    task automatic test_overflow;
        wrm(4'b0001, 4'b0010, 2'd0, 2'd1, 1'b0);
        tick();
        idle();
        @(negedge Clk);
        checks++;
        if (BufOvf !== 1'b1 || BufCnt !== 3'd4 || RszPxlData !== sb[0].d) begin
            errors++;
            $display("FAIL ovf_drop got ovf=%b cnt=%0d d=%h exp ovf=1 cnt=4 d=%h", BufOvf, BufCnt, RszPxlData, sb[0].d);
        end
        tick();
        RszPxlRdy = 1'b1;
        wrm(4'b0001, 4'b0010, 2'd0, 2'd1, 1'b1);
        tick();
        RszPxlRdy = 1'b0;
        idle();
        @(negedge Clk);
        checks++;
        if (BufCnt !== 3'd4 || RszPxlData !== sb[0].d || RszPxlXIdx !== 2'd1) begin
            errors++;
            $display("FAIL ovf_push_pop got cnt=%0d d=%h x=%0d exp cnt=4 d=%h x=1", BufCnt, RszPxlData, RszPxlXIdx, sb[0].d);
        end
        tick();
        RszPxlRdy = 1'b1;
        repeat (6) tick();
        @(negedge Clk);
        checks++;
        if (BufCnt !== 3'd0 || sb.size() !== 0 || OrdErr !== 1'b0 || MskErr !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain got cnt=%0d left=%0d ord=%b msk=%b exp cnt=0 left=0 ord=0 msk=0", BufCnt, sb.size(), OrdErr, MskErr);
        end
        tick();
    endtask

    task automatic test_mask_err;
        do_reset();
        RszPxlRdy = 1'b0;
        wrm(4'b0110, 4'b0001, 2'd1, 2'd0, 1'b1);
        tick();
        wrm(4'b0000, 4'b0001, 2'd0, 2'd0, 1'b1);
        tick();
        idle();
        @(negedge Clk);
        checks++;
        if (MskErr !== 1'b1 || RszPxlXIdx !== 2'd1) begin
            errors++;
            $display("FAIL mask_multi got msk=%b x=%0d exp msk=1 x=1", MskErr, RszPxlXIdx);
        end
        tick();
        RszPxlRdy = 1'b1;
        tick();
        @(negedge Clk);
        checks++;
        if (RszPxlXIdx !== 2'd0 || RszPxlVld !== 1'b1) begin
            errors++;
            $display("FAIL mask_zero got x=%0d vld=%b exp x=0 vld=1", RszPxlXIdx, RszPxlVld);
        end
        repeat (2) tick();
    endtask

    task automatic test_order_err;
        do_reset();
        RszPxlRdy = 1'b1;
        wrm(4'b0001, 4'b0001, 2'd0, 2'd0, 1'b1);
        tick();
        wrm(4'b0100, 4'b0001, 2'd2, 2'd0, 1'b1);
        tick();
        idle();
        @(negedge Clk);
        checks++;
        if (OrdErr !== 1'b0 || RszPxlVld !== 1'b1 || RszPxlXIdx !== 2'd2) begin
            errors++;
            $display("FAIL order_first got ord=%b vld=%b x=%0d exp ord=0 vld=1 x=2", OrdErr, RszPxlVld, RszPxlXIdx);
        end
        tick();
        @(negedge Clk);
        checks++;
        if (OrdErr !== 1'b1 || sb.size() !== 0) begin
            errors++;
            $display("FAIL order_second got ord=%b left=%0d exp ord=1 left=0", OrdErr, sb.size());
        end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        RszPxlRdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) RszPxlRdy = 1'b0;
            wrm(4'(1 << (i % 4)), 4'(1 << (i / 4)), 2'(i % 4), 2'(i / 4), 1'b1);
            tick();
        end
        idle();
        @(negedge Clk);
        checks++;
        if (BufCnt !== 3'd3) begin
            errors++;
            $display("FAIL mid_fill got cnt=%0d exp cnt=3", BufCnt);
        end
        tick();
        do_reset();
        @(negedge Clk);
        checks++;
        if (RszPxlVld !== 1'b0 || BufCnt !== 3'd0 || PxlBufRdy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got vld=%b cnt=%0d rdy=%b exp vld=0 cnt=0 rdy=1", RszPxlVld, BufCnt, PxlBufRdy);
        end
        tick();
        test_full_image();
    endtask

    initial begin
        test_reset();
        test_full_image();
        test_backpressure();
        test_overflow();
        test_mask_err();
        test_order_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
